// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX driver and the future RX block.
// Holds only types and constants, with no logic, latency or backpressure.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_IDX_W     = $clog2(UART_DATA_BITS);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Generic synchronous FIFO. Write-to-read latency is one cycle, and level_o updates on the edge after a push or pop.
// Pushes are ignored while full and pops while empty, so the caller gates pushes with !full_o.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_ok;
  logic             pop_ok;

  // The extra pointer MSB tells a full FIFO from an empty one when the low bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_byte_driver.sv
// 8N1 / 8N2 UART transmitter with an input FIFO. The start bit appears one edge after a push into an idle, empty FIFO.
// tx_ready is low only while the FIFO is full. A pop in the same cycle does not raise it.
module uart_tx_byte_driver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 236,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [UART_DATA_BITS-1:0]    tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int                    CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [UART_IDX_W-1:0] BIT_LAST  = UART_IDX_W'(UART_DATA_BITS - 1);
  localparam logic                  STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_tx_byte_driver: CLKS_PER_BIT must be in 2..65535");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_byte_driver: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_byte_driver: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_e              state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [UART_IDX_W-1:0]       bit_idx_q;
  logic                        stop_idx_q;
  logic [UART_DATA_BITS-1:0]   shift_q;
  logic                        uart_tx_q;
  logic                        busy_q;

  logic                        fifo_full;
  logic                        fifo_empty;
  logic [UART_DATA_BITS-1:0]   head;
  logic                        push;
  logic                        pop;
  logic                        cnt_zero;
  logic                        stop_done;

  assign tx_ready  = !fifo_full;
  assign push      = tx_valid && tx_ready;
  assign cnt_zero  = (cnt_q == '0);
  assign stop_done = (state_q == STOP) && cnt_zero && (stop_idx_q == STOP_LAST);
  assign pop       = !fifo_empty && ((state_q == IDLE) || stop_done);
  assign uart_tx   = uart_tx_q;
  assign busy      = busy_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (tx_data),
    .full_o     (fifo_full),
    .pop_i      (pop),
    .pop_dat_o  (head),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  // busy_q is the registered form of (next state != IDLE) || (next level != 0).
  // When staying in or falling back to IDLE the FIFO is empty, so the next level is just the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q   <= START;
            shift_q   <= head;
            uart_tx_q <= 1'b0;
            cnt_q     <= CNT_LOAD;
            busy_q    <= 1'b1;
          end else begin
            busy_q    <= push;
          end
        end
        START: begin
          if (cnt_zero) begin
            state_q   <= DATA;
            uart_tx_q <= shift_q[0];
            bit_idx_q <= '0;
            cnt_q     <= CNT_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_zero) begin
            cnt_q <= CNT_LOAD;
            if (bit_idx_q == BIT_LAST) begin
              state_q    <= STOP;
              uart_tx_q  <= 1'b1;
              stop_idx_q <= 1'b0;
            end else begin
              shift_q   <= shift_q >> 1;
              uart_tx_q <= shift_q[1];
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_zero) begin
            if (stop_idx_q == STOP_LAST) begin
              if (pop) begin
                state_q   <= START;
                shift_q   <= head;
                uart_tx_q <= 1'b0;
                cnt_q     <= CNT_LOAD;
              end else begin
                state_q <= IDLE;
                busy_q  <= push;
              end
            end else begin
              stop_idx_q <= 1'b1;
              cnt_q      <= CNT_LOAD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte_driver.sv
// Scoreboard bench: pushes queue the expected bytes, and per-line monitors decode frames and check bit timing and gaps.
// Uses two DUTs, one with defaults (8N1, 236 clk/bit) and one with 2 stop bits at 4 clk/bit.
module tb_uart_tx_byte_driver;

  localparam int C0 = 236;
  localparam int C1 = 4;

  typedef struct packed {
    logic [7:0] dat;
    logic       b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data0 = '0;
  logic [7:0] data1 = '0;
  logic       vld0 = 1'b0;
  logic       vld1 = 1'b0;
  logic       rdy0, rdy1, tx0, tx1, busy0, busy1;
  logic [2:0] lvl0, lvl1;

  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;
  exp_t exp0[$];
  exp_t exp1[$];

  uart_tx_byte_driver u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data0), .tx_valid(vld0), .tx_ready(rdy0),
    .uart_tx(tx0), .busy(busy0), .fifo_level(lvl0)
  );

  uart_tx_byte_driver #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(4), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_valid(vld1), .tx_ready(rdy1),
    .uart_tx(tx1), .busy(busy1), .fifo_level(lvl1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_line(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  task automatic run_mon(input int w, input int cpb, input int nb);
    exp_t       cur;
    logic [10:0] pat;
    logic [7:0] dec;
    logic       ln;
    int         errs;
    int         idx;
    int         end_cyc;
    bit         aborted;
    end_cyc = -100;
    forever begin
      @(negedge clk);
      if (rst_n && get_line(w) == 1'b0) begin
        if ((w == 0 ? exp0.size() : exp1.size()) == 0) begin
          check($sformatf("unexpected_frame_dut%0d", w), 32'd1, 32'd0);
          repeat (nb * cpb - 1) @(negedge clk);
          continue;
        end
        cur = (w == 0) ? exp0.pop_front() : exp1.pop_front();
        if (cur.b2b) check($sformatf("gap_dut%0d_%0h", w, cur.dat), cyc - end_cyc, 32'd1);
        pat = {2'b11, cur.dat, 1'b0};
        dec = '0;
        errs = 0;
        aborted = 1'b0;
        for (int pos = 0; pos < nb * cpb; pos++) begin
          if (pos > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          ln  = get_line(w);
          idx = pos / cpb;
          if (ln !== pat[idx]) errs++;
          if (idx >= 1 && idx <= 8 && (pos % cpb) == cpb / 2) dec[idx-1] = ln;
        end
        if (!aborted) begin
          check($sformatf("data_dut%0d", w), dec, cur.dat);
          check($sformatf("shape_dut%0d_%0h", w, cur.dat), errs, 32'd0);
          end_cyc = cyc;
        end
      end
    end
  endtask

  initial run_mon(0, C0, 10);
  initial run_mon(1, C1, 11);

  task automatic push(input int w, input logic [7:0] d, input bit b2b, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!((w == 0) ? rdy0 : rdy1) && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) begin
      check("push_ready_timeout", 32'd0, 32'd1);
      return;
    end
    e.dat = d;
    e.b2b = b2b;
    if (w == 0) begin data0 = d; vld0 = 1'b1; exp0.push_back(e); end
    else        begin data1 = d; vld1 = 1'b1; exp1.push_back(e); end
    @(posedge clk);
    #1;
    vld0 = 1'b0;
    vld1 = 1'b0;
  endtask

  task automatic wait_low(input int w);
    int n = 0;
    @(negedge clk);
    while (get_line(w) !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("wait_line_low_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy0 || busy1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #(800000);
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int fall_cyc;
    int n;
    int low_cnt;

    repeat (4) @(posedge clk);
    #1;
    check("rst_uart_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_tx_ready", rdy0, 1'b1);
    check("rst_level", lvl0, 3'd0);
    check("rst_uart_tx_dut1", tx1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: latency, level update and busy duration.
    push(0, 8'h55, 1'b0, w);
    check("push_line_still_idle", tx0, 1'b1);
    check("push_level", lvl0, 3'd1);
    check("push_busy", busy0, 1'b1);
    @(posedge clk);
    #1;
    check("start_bit_fall", tx0, 1'b0);
    check("pop_level", lvl0, 3'd0);
    fall_cyc = cyc;
    n = 0;
    while (busy0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_length", cyc - fall_cyc, 32'd2360);
    check("idle_line_after_frame", tx0, 1'b1);

    // Back-to-back bytes on consecutive cycles.
    wait_idle(200);
    push(0, 8'hA5, 1'b0, w);
    push(0, 8'h3C, 1'b1, w);
    wait_idle(6000);

    // FIFO full: one frame in flight, four queued, sixth held off.
    push(0, 8'h01, 1'b0, w);
    wait_low(0);
    push(0, 8'h02, 1'b1, w);
    push(0, 8'h03, 1'b1, w);
    push(0, 8'h04, 1'b1, w);
    push(0, 8'h05, 1'b1, w);
    check("full_level", lvl0, 3'd4);
    check("full_tx_ready", rdy0, 1'b0);
    push(0, 8'h06, 1'b1, w);
    check("holdoff_seen", (w > 0), 1'b1);
    check("level_after_refill", lvl0, 3'd4);
    wait_idle(16000);

    // Reset in the middle of DATA bit 3 of 0xF0 (a zero bit).
    push(0, 8'hF0, 1'b0, w);
    push(0, 8'h11, 1'b1, w);
    wait_low(0);
    repeat (C0 + 3 * C0 + C0 / 2) @(negedge clk);
    check("pre_reset_line_low", tx0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uart_tx", tx0, 1'b1);
    check("async_rst_level", lvl0, 3'd0);
    check("async_rst_busy", busy0, 1'b0);
    check("async_rst_tx_ready", rdy0, 1'b1);
    exp0.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 3 * C0; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1) low_cnt++;
    end
    check("post_reset_line_idle", low_cnt, 32'd0);
    check("post_reset_busy", busy0, 1'b0);
    push(0, 8'h5A, 1'b0, w);
    wait_idle(3000);

    // Two stop bits, 4 clk/bit: 44-cycle frames with no gap.
    push(1, 8'hFF, 1'b0, w);
    push(1, 8'h00, 1'b1, w);
    push(1, 8'h81, 1'b1, w);
    wait_idle(400);

    check("dut0_queue_drained", exp0.size(), 32'd0);
    check("dut1_queue_drained", exp1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
